// File: rtl/limit_arbiter.sv
// Round-robin arbiter feeding one shared unsigned clamp stage. Each channel
// carries its own run-time lower/upper bound pair.
module limit_arbiter #(
    parameter int N = 8,
    parameter int M = 4,
    parameter int W = 2
) (
    input  logic           Clk,
    input  logic           nReset,
    input  logic           CfgWrite,
    input  logic [W-1:0]   CfgChannel,
    input  logic [N-1:0]   CfgLower,
    input  logic [N-1:0]   CfgUpper,
    output logic           CfgError,
    input  logic [M-1:0]   Request,
    input  logic [M*N-1:0] Input,
    output logic [M-1:0]   Grant,
    output logic [N-1:0]   Output,
    output logic [W-1:0]   OutChannel,
    output logic           OutValid
);

    logic [N-1:0] lower_reg [M];
    logic [N-1:0] upper_reg [M];
    logic         cfg_ok;

    logic [M-1:0] eligible;
    logic         found;
    logic [W-1:0] winner;
    logic [M-1:0] grant_next;
    logic [W-1:0] pointer_reg;
    logic [W-1:0] pointer_next;

    logic         s1_valid_reg;
    logic [N-1:0] s1_sample_reg;
    logic [W-1:0] s1_chan_reg;
    logic [N-1:0] lo_sel;
    logic [N-1:0] hi_sel;
    logic [N-1:0] clamped;

    // A write is accepted only as a whole: valid channel and non-inverted bounds.
    assign cfg_ok = CfgWrite && ({1'b0, CfgChannel} < (W+1)'(M)) && (CfgLower <= CfgUpper);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < M; i++) begin
                lower_reg[i] <= '0;
                upper_reg[i] <= '1;
            end
            CfgError <= 1'b0;
        end else begin
            CfgError <= CfgWrite && !cfg_ok;
            if (cfg_ok) begin
                lower_reg[CfgChannel] <= CfgLower;
                upper_reg[CfgChannel] <= CfgUpper;
            end
        end
    end

    // Masking with the current grant stops any channel winning twice in a row.
    always_comb begin
        eligible     = Request & ~Grant;
        found        = 1'b0;
        winner       = '0;
        grant_next   = '0;
        pointer_next = pointer_reg;
        for (int k = 0; k < M; k++) begin
            if (!found && eligible[(int'(pointer_reg) + k) % M]) begin
                found  = 1'b1;
                winner = W'((int'(pointer_reg) + k) % M);
            end
        end
        if (found) begin
            grant_next[winner] = 1'b1;
            pointer_next       = (winner == W'(M - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Bounds are read before this edge's config write lands.
    always_comb begin
        lo_sel  = lower_reg[s1_chan_reg];
        hi_sel  = upper_reg[s1_chan_reg];
        clamped = s1_sample_reg;
        if (s1_sample_reg < lo_sel) begin
            clamped = lo_sel;
        end else if (s1_sample_reg > hi_sel) begin
            clamped = hi_sel;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Grant         <= '0;
            pointer_reg   <= '0;
            s1_valid_reg  <= 1'b0;
            s1_sample_reg <= '0;
            s1_chan_reg   <= '0;
            Output        <= '0;
            OutChannel    <= '0;
            OutValid      <= 1'b0;
        end else begin
            Grant        <= grant_next;
            pointer_reg  <= pointer_next;
            s1_valid_reg <= found;
            if (found) begin
                s1_sample_reg <= Input[winner*N +: N];
                s1_chan_reg   <= winner;
            end
            OutValid <= s1_valid_reg;
            if (s1_valid_reg) begin
                Output     <= clamped;
                OutChannel <= s1_chan_reg;
            end
        end
    end

endmodule
